// File: rtl/alu_seq.sv
// alu_seq: sequential N-bit ALU with registered carry/zero flags and iterative
// one-bit-per-cycle shifts under a START/BUSY/DONE handshake.
module alu_seq #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [2:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o,
    output logic         c_o,
    output logic         z_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] N_B = N'(N);
    localparam logic [CW-1:0] N_C = CW'(N);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t        state_q;
    logic [N-1:0]  y_q, work_q;
    logic          c_q, z_q, busy_q, done_q, dir_q;
    logic [CW-1:0] cnt_q, k;
    logic [N:0]    sum, diff;
    logic          cin, is_shift, dir, sh_c, res_c;
    logic [N-1:0]  src, sh_y, res_y;
    assign cin      = op_i[0] & c_q;
    assign sum      = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin};
    assign diff     = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, cin};
    assign is_shift = op_i[2] & op_i[1];
    assign k        = (b_i >= N_B) ? N_C : b_i[CW-1:0];
    // The same one-bit shifter serves the first step (from A) and every later step (from work_q).
    assign dir      = (state_q == IDLE) ? op_i[0] : dir_q;
    assign src      = (state_q == IDLE) ? a_i : work_q;
    assign sh_y     = dir ? {1'b0, src[N-1:1]} : {src[N-2:0], 1'b0};
    assign sh_c     = dir ? src[0] : src[N-1];
    assign res_y    = op_i[2] ? (op_i[1] ? ((k == '0) ? a_i : sh_y)
                                         : (op_i[0] ? (a_i | b_i) : (a_i & b_i)))
                              : (op_i[1] ? diff[N-1:0] : sum[N-1:0]);
    assign res_c    = op_i[2] ? (op_i[1] & (k != '0) & sh_c)
                              : (op_i[1] ? diff[N] : sum[N]);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            y_q     <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            work_q  <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && is_shift && k > CW'(1)) begin
                        work_q  <= sh_y;
                        dir_q   <= op_i[0];
                        cnt_q   <= k - 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else if (start_i) begin
                        y_q    <= res_y;
                        c_q    <= res_c;
                        z_q    <= (res_y == '0);
                        done_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    work_q <= sh_y;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        y_q     <= sh_y;
                        c_q     <= sh_c;
                        z_q     <= (sh_y == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign y_o    = y_q;
    assign c_o    = c_q;
    assign z_o    = z_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;
    logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [2:0]   op = '0;
    logic [N-1:0] a = '0, b = '0;
    logic [N-1:0] y;
    logic         c, z, busy, done;
    int n_chk = 0, n_fail = 0;
    int m_y = 0, m_c = 0, m_z = 0;

    alu_seq #(.N(N)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .y_o(y), .c_o(c), .z_o(z), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model(input int o, input int av, input int bv,
                         output int ey, output int ec, output int lat);
        int k;
        k   = (bv > N) ? N : bv;
        lat = 0;
        case (o)
            0: begin ey = (av + bv) & MASK;        ec = (av + bv) > MASK; end
            1: begin ey = (av + bv + m_c) & MASK;  ec = (av + bv + m_c) > MASK; end
            2: begin ey = (av - bv) & MASK;        ec = av < bv; end
            3: begin ey = (av - bv - m_c) & MASK;  ec = av < (bv + m_c); end
            4: begin ey = av & bv;                 ec = 0; end
            5: begin ey = av | bv;                 ec = 0; end
            6: begin
                ey  = (av << k) & MASK;
                ec  = (k == 0) ? 0 : (av >> (N - k)) & 1;
                lat = (k >= 2) ? k - 1 : 0;
            end
            default: begin
                ey  = av >> k;
                ec  = (k == 0) ? 0 : (av >> (k - 1)) & 1;
                lat = (k >= 2) ? k - 1 : 0;
            end
        endcase
    endtask

    task automatic run_op(input int o, input int av, input int bv);
        int ey, ec, lat, cyc;
        model(o, av, bv, ey, ec, lat);
        op = 3'(o); a = N'(av); b = N'(bv); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            check("busy_during_shift", busy, 1);
            check("y_hold_during_shift", y, m_y);
            check("c_hold_during_shift", c, m_c);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, lat);
        check("done", done, 1);
        check("busy_at_done", busy, 0);
        check("y", y, ey);
        check("c", c, ec);
        check("z", z, ey == 0);
        m_y = ey; m_c = ec; m_z = (ey == 0);
        @(posedge clk); #1;
        check("done_single_pulse", done, 0);
        check("y_held_after", y, m_y);
        check("z_held_after", z, m_z);
    endtask

    initial begin
        #3 rst = 1'b1;
        #1;
        check("rst_y", y, 0); check("rst_c", c, 0); check("rst_z", z, 0);
        check("rst_busy", busy, 0); check("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(0, 5, 3);
        run_op(0, 15, 3);
        run_op(1, 0, 0);
        run_op(2, 3, 5);
        run_op(3, 5, 4);
        // SHL 1011 by 3 with START held during BUSY, then a new ADD during the DONE cycle
        op = 3'd6; a = 4'b1011; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        check("shl_e0_busy", busy, 1); check("shl_e0_done", done, 0); check("shl_e0_y", y, m_y);
        op = 3'd0; a = 4'd7; b = 4'd7;
        @(posedge clk); #1;
        check("shl_e1_busy", busy, 1); check("shl_e1_done", done, 0); check("shl_e1_y", y, m_y);
        @(posedge clk); #1;
        check("shl_e2_done", done, 1); check("shl_e2_busy", busy, 0);
        check("shl_y", y, 8); check("shl_c", c, 1); check("shl_z", z, 0);
        a = 4'd2; b = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done", done, 1); check("b2b_y", y, 5); check("b2b_c", c, 0); check("b2b_busy", busy, 0);
        m_y = 5; m_c = 0; m_z = 0;
        @(posedge clk); #1;
        check("b2b_done_fall", done, 0);
        run_op(7, 9, 7);
        run_op(7, 6, 0);
        run_op(6, 5, 1);
        // Reset in the second cycle of a 4-step SHL aborts it without DONE
        op = 3'd6; a = 4'b1011; b = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_y", y, 0); check("abort_c", c, 0); check("abort_z", z, 0);
        check("abort_busy", busy, 0); check("abort_done", done, 0);
        m_y = 0; m_c = 0; m_z = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
            check("abort_y_held", y, 0);
        end
        run_op(0, 5, 3);
        repeat (60) run_op($urandom_range(0, 7), $urandom_range(0, MASK), $urandom_range(0, MASK));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
